uart_tx: RTL

Serial transmitter for the UART protocol; counterpart of the `uart_rx` receiver in the same design. It accepts a parallel word through a valid/busy handshake and serialises it as a frame on `s_data`. The frame is start bit, DWIDTH data bits LSB first, an optional parity bit, then one stop bit. Each bit lasts `prescale` clock cycles, so the same prescale setting used on the receive side sets the line rate.

---
 rtl/uart_tx_pkg.sv | 28 ++
 rtl/tx_bit_counter.sv | 46 ++++
 rtl/uart_tx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, parity-type constants and the idle line level.
// The state names match those used by the receive-side FSM where they coincide.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    localparam logic ParityEven = 1'b0;
    localparam logic ParityOdd  = 1'b1;
    localparam logic LineIdle   = 1'b1;

    // xor_all is the reduction XOR of the data word.
    function automatic logic parity_of(input logic xor_all, input logic ptype);
        logic p;
        unique case (ptype)
            ParityEven: p = xor_all;
            ParityOdd:  p = ~xor_all;
            default:    p = xor_all;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Bit timing for the UART transmitter: edge_cnt paces each bit, bit_cnt indexes data bits.
module tx_bit_counter #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned PWIDTH = 6,
    parameter int unsigned BCW    = $clog2(DWIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              data_phase,
    input  logic [PWIDTH-1:0] prescale,
    output logic              bit_done,
    output logic [BCW-1:0]    bit_cnt
);

    logic [PWIDTH-1:0] edge_cnt_q;
    logic [BCW-1:0]    bit_cnt_q;
    logic [PWIDTH-1:0] last_edge;

    // A prescale of 0 behaves as 1; the terminal count never exceeds 2^PWIDTH-2.
    always_comb begin
        last_edge = (prescale == '0) ? '0 : prescale - 1'b1;
        bit_done  = enable && (edge_cnt_q == last_edge);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            if (!enable || bit_done) begin
                edge_cnt_q <= '0;
            end else begin
                edge_cnt_q <= edge_cnt_q + 1'b1;
            end
            if (!data_phase) begin
                bit_cnt_q <= '0;
            end else if (bit_done) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: latches a word on a valid/busy handshake and sends start, data (LSB first),
// optional parity and stop bits, each held for prescale cycles. Outputs are registered.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned PWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] p_data,
    input  logic              data_valid,
    input  logic              parity_en,
    input  logic              parity_type,
    input  logic [PWIDTH-1:0] prescale,
    output logic              s_data,
    output logic              busy
);

    localparam int unsigned    BCW     = $clog2(DWIDTH + 1);
    localparam logic [BCW-1:0] LastBit = BCW'(DWIDTH - 1);

    tx_state_e         state_q, state_d;
    logic [DWIDTH-1:0] data_q;
    logic              par_en_q;
    logic              par_type_q;
    logic [PWIDTH-1:0] prescale_q;
    logic              s_data_q, s_data_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              bit_done;
    logic [BCW-1:0]    bit_cnt;
    logic [BCW-1:0]    idx_next;
    logic [DWIDTH-1:0] data_shifted;
    logic              parity_bit;

    assign accept     = (state_q == StIdle) && data_valid;
    assign parity_bit = parity_of(^data_q, par_type_q);

    tx_bit_counter #(
        .DWIDTH (DWIDTH),
        .PWIDTH (PWIDTH),
        .BCW    (BCW)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .enable     (state_q != StIdle),
        .data_phase (state_q == StData),
        .prescale   (prescale_q),
        .bit_done   (bit_done),
        .bit_cnt    (bit_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            s_data_q   <= LineIdle;
            busy_q     <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            prescale_q <= '0;
        end else begin
            state_q  <= state_d;
            s_data_q <= s_data_d;
            busy_q   <= busy_d;
            if (accept) begin
                data_q     <= p_data;
                par_en_q   <= parity_en;
                par_type_q <= parity_type;
                prescale_q <= prescale;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (data_valid) state_d = StStart;
            StStart:  if (bit_done) state_d = StData;
            StData: begin
                if (bit_done && (bit_cnt == LastBit)) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: if (bit_done) state_d = StStop;
            StStop:   if (bit_done) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs are computed for the upcoming state so the flops present them without delay.
    always_comb begin
        idx_next = '0;
        if (state_q == StData) begin
            idx_next = bit_done ? bit_cnt + 1'b1 : bit_cnt;
        end
        data_shifted = data_q >> idx_next;
        s_data_d     = LineIdle;
        busy_d       = 1'b1;
        unique case (state_d)
            StIdle: begin
                s_data_d = LineIdle;
                busy_d   = 1'b0;
            end
            StStart:  s_data_d = 1'b0;
            StData:   s_data_d = data_shifted[0];
            StParity: s_data_d = parity_bit;
            StStop:   s_data_d = 1'b1;
            default: begin
                s_data_d = LineIdle;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign s_data = s_data_q;
    assign busy   = busy_q;

endmodule
